// File: rtl/micro_ondas_pkg.sv
// Shared types and helpers for the microwave controller: FSM states,
// seven-segment codes and the power/duty constants.
package micro_ondas_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

    localparam int POWER_MAX   = 10;
    localparam int DUTY_WINDOW = 10;

    // {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    function automatic logic [6:0] bcd_to_segs(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/decod_7seg.sv
// One BCD digit to seven-segment decoder; non-decimal codes blank the digit.
module decod_7seg
    import micro_ondas_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] segs_o
);

    assign segs_o = bcd_to_segs(bcd_i);

endmodule

// File: rtl/micro_ondas_multi.sv
// Microwave controller: keypad BCD entry, real-time countdown, power-level
// duty cycling, pause/resume and a timed completion beep.
module micro_ondas_multi
    import micro_ondas_pkg::*;
#(
    parameter int MIN_DIGITS    = 1,
    parameter int TICKS_PER_SEC = 100,
    parameter int BEEP_SECS     = 3
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [9:0]              keypad,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    clearn,
    input  logic                    powern,
    input  logic                    door_closed,
    output logic [6:0]              sec_ones_segs,
    output logic [6:0]              sec_tens_segs,
    output logic [7*MIN_DIGITS-1:0] mins_segs,
    output logic                    mag_on,
    output logic                    beep
);

    localparam int PW     = $clog2(TICKS_PER_SEC);
    localparam int BEEP_N = BEEP_SECS * TICKS_PER_SEC;
    localparam int BW     = $clog2(BEEP_N);

    state_e                       state_q, state_d;
    logic [3:0]                   ones_q, ones_d, tens_q, tens_d, ones_dec, tens_dec;
    logic [MIN_DIGITS-1:0][3:0]   mins_q, mins_d, mins_dec;
    logic [3:0]                   power_q, power_d, duty_q, duty_d;
    logic                         arm_q, arm_d;
    logic [9:0]                   kp_prev_q;
    logic [PW-1:0]                presc_q, presc_d;
    logic [BW-1:0]                beep_cnt_q, beep_cnt_d;
    logic [3:0]                   key_val;
    logic                         key_press, tick, time_zero, dec_zero, brw;

    // A press needs a clean 0 -> one-hot edge, so held or multi-hot keys never re-arm
    assign key_press = $onehot(keypad) && (kp_prev_q == '0);
    assign tick      = (presc_q == PW'(TICKS_PER_SEC - 1));
    assign time_zero = (ones_q == '0) && (tens_q == '0) && (mins_q == '0);
    assign dec_zero  = (ones_dec == '0) && (tens_dec == '0) && (mins_dec == '0);

    always_comb begin
        key_val = '0;
        for (int k = 0; k < 10; k++)
            if (keypad[k]) key_val = 4'(k);
    end

    // One-second BCD decrement with borrow rippling ones -> tens -> minutes
    always_comb begin
        brw      = (ones_q == '0);
        ones_dec = brw ? 4'd9 : ones_q - 4'd1;
        tens_dec = tens_q;
        if (brw) begin
            tens_dec = (tens_q == '0) ? 4'd5 : tens_q - 4'd1;
            brw      = (tens_q == '0);
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            mins_dec[i] = mins_q[i];
            if (brw) begin
                mins_dec[i] = (mins_q[i] == '0) ? 4'd9 : mins_q[i] - 4'd1;
                brw         = (mins_q[i] == '0);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (clearn && stopn && !startn && door_closed && !time_zero)
                         state_d = S_RUN;
            S_RUN:   if (!clearn || !door_closed || !stopn) state_d = S_PAUSE;
                     else if (tick && dec_zero)             state_d = S_DONE;
            S_PAUSE: if (!clearn)                                 state_d = S_IDLE;
                     else if (door_closed && stopn && !startn)    state_d = S_RUN;
            S_DONE:  if (!clearn || !door_closed || !stopn || !startn ||
                         beep_cnt_q == BW'(BEEP_N - 1))
                         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mag_on = (state_q == S_RUN) && door_closed && (duty_q < power_q);
        beep   = (state_q == S_DONE);
    end

    always_comb begin
        ones_d     = ones_q;
        tens_d     = tens_q;
        mins_d     = mins_q;
        power_d    = power_q;
        arm_d      = arm_q;
        presc_d    = presc_q;
        duty_d     = duty_q;
        beep_cnt_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (!clearn) begin
                    ones_d  = '0;
                    tens_d  = '0;
                    mins_d  = '0;
                    power_d = 4'(POWER_MAX);
                    arm_d   = 1'b0;
                end else if (state_d == S_RUN) begin
                    presc_d = '0;
                    duty_d  = '0;
                end else if (key_press) begin
                    if (arm_q) begin
                        power_d = (key_val == '0) ? 4'(POWER_MAX) : key_val;
                        arm_d   = 1'b0;
                    end else begin
                        ones_d    = key_val;
                        tens_d    = ones_q;
                        mins_d[0] = tens_q;
                        for (int i = 1; i < MIN_DIGITS; i++) mins_d[i] = mins_q[i-1];
                    end
                end else if (!powern) begin
                    arm_d = 1'b1;
                end
            end
            S_RUN: if (state_d != S_PAUSE) begin
                if (tick) begin
                    presc_d = '0;
                    ones_d  = ones_dec;
                    tens_d  = tens_dec;
                    mins_d  = mins_dec;
                    duty_d  = (duty_q == 4'(DUTY_WINDOW - 1)) ? '0 : duty_q + 4'd1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_PAUSE: if (!clearn) begin
                ones_d = '0;
                tens_d = '0;
                mins_d = '0;
            end
            S_DONE: if (state_d == S_DONE) beep_cnt_d = beep_cnt_q + BW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ones_q     <= '0;
            tens_q     <= '0;
            mins_q     <= '0;
            power_q    <= 4'(POWER_MAX);
            arm_q      <= 1'b0;
            kp_prev_q  <= '0;
            presc_q    <= '0;
            duty_q     <= '0;
            beep_cnt_q <= '0;
        end else begin
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            mins_q     <= mins_d;
            power_q    <= power_d;
            arm_q      <= arm_d;
            kp_prev_q  <= keypad;
            presc_q    <= presc_d;
            duty_q     <= duty_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    decod_7seg u_ones (.bcd_i(ones_q), .segs_o(sec_ones_segs));
    decod_7seg u_tens (.bcd_i(tens_q), .segs_o(sec_tens_segs));

    for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_min
        decod_7seg u_min (.bcd_i(mins_q[i]), .segs_o(mins_segs[7*i +: 7]));
    end

endmodule

// File: tb/tb_micro_ondas_multi.sv
// Bench for micro_ondas_multi: keypad table, directed timing sequences and a
// randomized run checked against an integer-time reference model.
module tb_micro_ondas_multi;

    localparam int TPS = 4;
    localparam int BS  = 3;
    localparam int MD  = 2;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic          clock = 1'b0;
    logic          resetn, startn, stopn, clearn, powern, door_closed;
    logic [9:0]    keypad;
    logic [6:0]    sec_ones_segs, sec_tens_segs;
    logic [7*MD-1:0] mins_segs;
    logic          mag_on, beep;

    int checks = 0;
    int errors = 0;
    bit model_en = 0;

    // reference model: time held as the displayed decimal number mmss
    int m_state, m_time, m_power, m_duty, m_presc, m_done;
    bit m_arm;
    logic [9:0] m_prev;

    micro_ondas_multi #(.MIN_DIGITS(MD), .TICKS_PER_SEC(TPS), .BEEP_SECS(BS)) dut (
        .clock(clock), .resetn(resetn), .keypad(keypad), .startn(startn),
        .stopn(stopn), .clearn(clearn), .powern(powern), .door_closed(door_closed),
        .sec_ones_segs(sec_ones_segs), .sec_tens_segs(sec_tens_segs),
        .mins_segs(mins_segs), .mag_on(mag_on), .beep(beep)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg7(int d);
        case (d)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
            4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
            8: return 7'h7F; 9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [27:0] disp_of(int d);
        return {seg7((d / 1000) % 10), seg7((d / 100) % 10), seg7((d / 10) % 10), seg7(d % 10)};
    endfunction

    function automatic int dec_time(int d);
        // mm:00 borrows a minute and becomes (mm-1):59
        return (d % 100 == 0) ? d - 41 : d - 1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic chk_disp(string nm, int d);
        chk(nm, {4'h0, mins_segs, sec_tens_segs, sec_ones_segs}, {4'h0, disp_of(d)});
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_time = 0; m_power = 10; m_duty = 0;
        m_presc = 0; m_done = 0; m_arm = 0; m_prev = '0;
    endtask

    task automatic model_step();
        bit kp;
        int kv;
        kp = ($countones(keypad) == 1) && (m_prev == '0);
        kv = 0;
        for (int k = 0; k < 10; k++) if (keypad[k]) kv = k;
        case (m_state)
            M_IDLE:
                if (!clearn) begin m_time = 0; m_power = 10; m_arm = 0; end
                else if (stopn && !startn && door_closed && m_time != 0) begin
                    m_state = M_RUN; m_presc = 0; m_duty = 0;
                end else if (kp) begin
                    if (m_arm) begin m_power = (kv == 0) ? 10 : kv; m_arm = 0; end
                    else m_time = (m_time * 10 + kv) % 10000;
                end else if (!powern) m_arm = 1;
            M_RUN:
                if (!clearn || !door_closed || !stopn) m_state = M_PAUSE;
                else if (m_presc == TPS - 1) begin
                    m_presc = 0;
                    m_time  = dec_time(m_time);
                    m_duty  = (m_duty + 1) % 10;
                    if (m_time == 0) begin m_state = M_DONE; m_done = 0; end
                end else m_presc++;
            M_PAUSE:
                if (!clearn) begin m_state = M_IDLE; m_time = 0; end
                else if (door_closed && stopn && !startn) m_state = M_RUN;
            default: begin
                m_done++;
                if (!clearn || !door_closed || !stopn || !startn || m_done >= BS * TPS)
                    m_state = M_IDLE;
            end
        endcase
        m_prev = keypad;
    endtask

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clock);
            if (model_en) model_step();
            #1;
        end
    endtask

    task automatic press(int k);
        keypad = 10'(1 << k); cyc();
        keypad = '0;          cyc();
    endtask

    task automatic start_pulse();
        startn = 1'b0; cyc(); startn = 1'b1;
    endtask

    typedef struct { logic [9:0] kp; logic pwn; logic clrn; int d; } vec_t;
    vec_t tbl[18];

    initial begin
        tbl[0]  = '{10'b0000000000, 1'b1, 1'b1, 0};
        tbl[1]  = '{10'b0000000100, 1'b1, 1'b1, 2};
        tbl[2]  = '{10'b0000000000, 1'b1, 1'b1, 2};
        tbl[3]  = '{10'b0000000010, 1'b1, 1'b1, 21};
        tbl[4]  = '{10'b0000000010, 1'b1, 1'b1, 21};
        tbl[5]  = '{10'b0000000000, 1'b1, 1'b1, 21};
        tbl[6]  = '{10'b0000000110, 1'b1, 1'b1, 21};
        tbl[7]  = '{10'b0000000100, 1'b1, 1'b1, 21};
        tbl[8]  = '{10'b0000000000, 1'b1, 1'b1, 21};
        tbl[9]  = '{10'b0000100000, 1'b1, 1'b1, 215};
        tbl[10] = '{10'b0000000000, 1'b1, 1'b1, 215};
        tbl[11] = '{10'b0010000000, 1'b1, 1'b1, 2157};
        tbl[12] = '{10'b0000000000, 1'b1, 1'b1, 2157};
        tbl[13] = '{10'b0000001000, 1'b1, 1'b1, 1573};
        tbl[14] = '{10'b0000000000, 1'b0, 1'b1, 1573};
        tbl[15] = '{10'b0000000001, 1'b1, 1'b1, 1573};
        tbl[16] = '{10'b0000000000, 1'b1, 1'b1, 1573};
        tbl[17] = '{10'b0000000000, 1'b1, 1'b0, 0};

        keypad = '0; startn = 1; stopn = 1; clearn = 1; powern = 1; door_closed = 1;
        resetn = 0;
        #12;
        chk_disp("reset_disp", 0);
        chk("reset_mag_beep", {30'd0, mag_on, beep}, 32'd0);
        resetn = 1;
        cyc();

        for (int i = 0; i < 18; i++) begin
            keypad = tbl[i].kp; powern = tbl[i].pwn; clearn = tbl[i].clrn;
            cyc();
            chk_disp($sformatf("table_%0d", i), tbl[i].d);
        end
        keypad = '0; powern = 1; clearn = 1;
        cyc();

        // 00:21 full countdown and beep
        press(2); press(1);
        chk_disp("entry_21", 21);
        start_pulse();
        chk("start_mag", {31'd0, mag_on}, 32'd1);
        cyc(3);  chk_disp("pre_first_tick", 21);
        cyc();   chk_disp("first_tick_20", 20);
        cyc(79); chk_disp("last_second", 1);
        chk("not_done_yet", {31'd0, beep}, 32'd0);
        cyc();   chk("done_beep", {30'd0, mag_on, beep}, 32'd1);
        chk_disp("done_zero", 0);
        cyc(11); chk("beep_held", {31'd0, beep}, 32'd1);
        cyc();   chk("beep_ends", {31'd0, beep}, 32'd0);

        // minute borrow, then tens above 5
        press(1); press(0); press(0);
        chk_disp("entry_100", 100);
        start_pulse(); cyc(4);
        chk_disp("borrow_059", 59);
        clearn = 0; cyc();
        chk("pause_mag", {31'd0, mag_on}, 32'd0);
        cyc(); clearn = 1;
        chk_disp("clear_in_pause", 0);
        press(9); press(0);
        start_pulse(); cyc(4);
        chk_disp("tens90_to_89", 89);
        clearn = 0; cyc(2); clearn = 1;

        // door open mid-second, resume keeps prescaler phase
        press(5);
        start_pulse(); cyc(2);
        door_closed = 0; #1;
        chk("door_mag_drop", {31'd0, mag_on}, 32'd0);
        cyc(5);
        chk_disp("pause_frozen", 5);
        door_closed = 1;
        start_pulse();
        chk("resume_mag", {31'd0, mag_on}, 32'd1);
        cyc();   chk_disp("resume_pre_tick", 5);
        cyc();   chk_disp("resume_tick", 4);
        clearn = 0; cyc(2); clearn = 1;

        // power level 3: 12 cycles on, 28 off per 10 s window
        powern = 0; cyc(); powern = 1;
        press(3);
        chk_disp("power_key_no_digit", 0);
        press(2); press(0);
        start_pulse();
        for (int k = 0; k < 80; k++) begin
            chk($sformatf("duty_k%0d", k), {31'd0, mag_on}, ((k % 40) < 12) ? 32'd1 : 32'd0);
            cyc();
        end
        chk("power_done", {31'd0, beep}, 32'd1);
        start_pulse();
        chk("done_abort", {31'd0, beep}, 32'd0);

        // start ignored at 00:00
        start_pulse();
        chk("start_at_zero", {31'd0, mag_on}, 32'd0);

        // held key enters once
        keypad = 10'b0010000000; cyc(20); keypad = '0; cyc();
        chk_disp("held_key", 7);

        // async reset mid-run
        start_pulse(); cyc(4);
        chk_disp("run_before_reset", 6);
        chk("mag_before_reset", {31'd0, mag_on}, 32'd1);
        #2 resetn = 0; #1;
        chk_disp("async_reset_disp", 0);
        chk("async_reset_out", {30'd0, mag_on, beep}, 32'd0);
        cyc(); resetn = 1;

        // randomized run against the reference model
        model_reset();
        model_en = 1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 55)      keypad = '0;
                else if (r < 92) keypad = 10'(1 << $urandom_range(0, 9));
                else             keypad = 10'($urandom);
            end
            startn = ($urandom_range(0, 99) >= 6);
            stopn  = ($urandom_range(0, 99) >= 2);
            clearn = ($urandom_range(0, 99) >= 1);
            powern = ($urandom_range(0, 99) >= 3);
            if (door_closed) door_closed = ($urandom_range(0, 99) >= 1);
            else             door_closed = ($urandom_range(0, 99) < 15);
            #1;
            chk($sformatf("rand_%0d", n),
                {2'b00, mins_segs, sec_tens_segs, sec_ones_segs, mag_on, beep},
                {2'b00, disp_of(m_time),
                 (m_state == M_RUN) && door_closed && (m_duty < m_power),
                 (m_state == M_DONE)});
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/micro_ondas_multi.md
# micro_ondas_multi

Parametrised microwave-oven controller, successor to the single-minute-digit `micro_ondas`. It takes one-hot keypad entry into a BCD time register, counts down in real time from a fast system clock, and drives active-high seven-segment displays with a configurable number of minute digits. Compared with its predecessor it adds:
- magnetron power levels, implemented as on/off cycling within each 10 s window;
- pause/resume on `stopn` or door opening;
- a timed completion beep.

## Interface
Parameters:
- `MIN_DIGITS`, default 1: number of BCD minute digits, legal range 1..3.
- `TICKS_PER_SEC`, default 100: clock cycles per second, minimum 2.
- `BEEP_SECS`, default 3: duration of `beep` in DONE, in seconds, minimum 1.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clock`  in  1: single system clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `keypad`  in  10: one-hot digit keys; bit k = digit k.
- `startn`  in  1: active-low start/resume, level-sampled.
- `stopn`  in  1: active-low pause, level-sampled.
- `clearn`  in  1: active-low functional clear, synchronous.
- `powern`  in  1: active-low; arms power-level entry.
- `door_closed`  in  1: 1 = door closed.
- `sec_ones_segs`  out  7: seconds-ones display, {g,f,e,d,c,b,a}, active high.
- `sec_tens_segs`  out  7: seconds-tens display.
- `mins_segs`  out  7*MIN_DIGITS: minute displays; least-significant digit in bits [6:0].
- `mag_on`  out  1: magnetron enable.
- `beep`  out  1: completion tone enable.

## Operation
States: IDLE, RUN, PAUSE, DONE.

Input priority within a cycle: `clearn` > door open > `stopn` > `startn`.

Key press:
- A key press is detected when `keypad` has exactly one bit set and `keypad` was 0 in the previous cycle.
- Multi-hot values are ignored and do not arm a new press.
- A held key enters once.

IDLE:
- Key press with power entry disarmed: shift the digits left (mins[n] <- mins[n-1], mins0 <- tens, tens <- ones, ones <- key). The top minute digit is discarded.
- `powern` low arms power entry. The next key press sets `power` (key 0 means 10) and disarms power entry; the time digits are unchanged.
- `clearn` low: all digits <- 0, `power` <- 10, power entry disarmed.
- `startn` low, `door_closed` = 1 and time nonzero -> RUN. On this transition the prescaler and the duty counter are reset to 0.
- `startn` low with time 0:00 is ignored.

RUN:
- Prescaler counts 0..TICKS_PER_SEC-1. A tick occurs when it wraps.
- On each tick, decrement the time in BCD:
  - ones 0 -> 9 with borrow;
  - tens 0 -> 5 with borrow into minutes;
  - minute digits 0 -> 9 with borrow.
  - Entered tens digits above 5 decrement naturally (90 -> 89 ...).
- On each tick, the duty counter (0..9) advances.
- Tick that produces an all-zero time -> DONE.
- `clearn` low, door open or `stopn` low -> PAUSE. The prescaler, duty counter and digits are held.

PAUSE:
- `startn` low with `door_closed` = 1 -> RUN, with the prescaler and duty counter preserved.
- `clearn` low -> IDLE with digits zeroed; `power` is kept.
- Keypad is ignored.

DONE:
- Display shows all zeros.
- `beep` = 1 for BEEP_SECS*TICKS_PER_SEC cycles, then -> IDLE.
- `startn`, `stopn` or `clearn` low, or door open -> IDLE immediately, with `beep` dropping in the same cycle.

Outputs:
- `mag_on` = (state == RUN) && `door_closed` && (duty < `power`). This is combinational from registered state, so a door opening drops `mag_on` in the same cycle.
- `beep` = (state == DONE).
- Each display is the combinational seven-segment decode of its digit. 0 = 0111111, 1 = 0000110, 9 = 1101111.

## Timing
Reset (`resetn` low, asynchronous, at any time including mid-RUN):
- state IDLE;
- all digits 0, so every display reads 0111111;
- `power` 10;
- prescaler, duty counter and beep counter 0;
- `mag_on` 0, `beep` 0;
- power entry disarmed, previous-keypad register 0.

Latencies:
- Key press: the digit appears on the displays the cycle after the edge on which it is sampled.
- `startn` sampled low at edge N -> RUN and `mag_on` = 1 after edge N.
- The first decrement occurs TICKS_PER_SEC cycles after entering RUN from IDLE.
- Time T seconds -> DONE after T*TICKS_PER_SEC cycles of RUN, pauses excluded.

## Structure
- Package `micro_ondas_pkg`:
  - state enum;
  - seven-segment constants and `bcd_to_segs` function;
  - `POWER_MAX` = 10;
  - `DUTY_WINDOW` = 10.
- Sub-module `decod_7seg`: one 4-bit BCD to 7-segment decoder, instantiated 2+MIN_DIGITS times. Codes above 9 produce 0000000.
- Top level holds the FSM, BCD digit array, prescaler, duty counter and beep counter.

## Test plan
Use TICKS_PER_SEC=4, BEEP_SECS=3, MIN_DIGITS=2.
- Keys 2 then 1, then `startn` low for 1 cycle:
  - displays read 00:21;
  - `mag_on` = 1 on the next cycle;
  - 00:20 after 4 cycles;
  - DONE after 84 cycles;
  - `beep` high for 12 cycles, then IDLE.
- Keys 1,0,0, start -> 01:00, then 00:59 after 4 cycles. Keys 9,0, start -> 90 then 89.
- Door opened mid-second in RUN:
  - `mag_on` drops in the same cycle;
  - display frozen in PAUSE.
  - Close the door and pulse `startn` -> the next tick arrives after the remaining prescaler count.
- `powern` then key 3, time 20 s, run -> `mag_on` = 1 for 12 cycles, then 0 for 28 cycles, repeated twice.
- Keypad edge and guard cases:
  - keypad 0000000110 -> no entry;
  - key held 20 cycles -> one entry;
  - `startn` at 00:00 -> stays IDLE;
  - `clearn` in PAUSE -> IDLE, 00:00.
- `resetn` pulsed low mid-RUN:
  - all outputs go to reset values without a clock edge;
  - displays read 0111111.
